// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - PC redirect arbitration and fetch sequencing
// Holds a redirect across instruction-memory misses and freezes fetch on halt.
module fetch_redirect_ctrl #(
  parameter int WORD_W             = 32,
  parameter bit RESET_STATE_HALTED = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              stall,
  input  logic              halt,
  input  logic              ex_br_req,
  input  logic [WORD_W-1:0] ex_br_target,
  input  logic              ex_jr_req,
  input  logic [WORD_W-1:0] ex_jr_target,
  input  logic              id_j_req,
  input  logic [WORD_W-1:0] id_j_target,
  output logic              pc_en,
  output logic              pc_sel,
  output logic [WORD_W-1:0] pc_target,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              imemREN,
  output logic              redirect_pending,
  output logic              halted
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_held_target;
  logic              r_held_ex;

  logic              w_req;
  logic              w_req_ex;
  logic [WORD_W-1:0] w_ex_target;
  logic [WORD_W-1:0] w_req_target;
  logic              w_ex_override;

  logic [1:0]        w_next_state;
  logic              w_load;
  logic              w_clear;
  logic              w_pc_en;
  logic              w_pc_sel;
  logic [WORD_W-1:0] w_pc_target;
  logic              w_flush_ifid;
  logic              w_flush_idex;
  logic              w_imem_ren;
  logic              w_pending;
  logic              w_halted;

  // Older instruction wins: EX before ID, branch before jump-register.
  assign w_req_ex      = ex_br_req | ex_jr_req;
  assign w_req         = w_req_ex | id_j_req;
  assign w_ex_target   = ex_br_req ? ex_br_target : ex_jr_target;
  assign w_req_target  = w_req_ex ? w_ex_target : id_j_target;
  assign w_ex_override = w_req_ex & ~r_held_ex;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_pc_en      = 1'b0;
    w_pc_sel     = 1'b0;
    w_pc_target  = '0;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    w_imem_ren   = 1'b0;
    w_pending    = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_RUN: begin
        w_imem_ren = 1'b1;
        if (w_req) begin
          w_pc_sel    = 1'b1;
          w_pc_target = w_req_target;
        end
        if (halt) begin
          w_next_state = S_HALT;
        end else if (w_req && ihit) begin
          w_pc_en      = 1'b1;
          w_flush_ifid = 1'b1;
          w_flush_idex = w_req_ex;
        end else if (w_req) begin
          w_load       = 1'b1;
          w_next_state = S_PEND;
        end else begin
          w_pc_en = ihit & ~stall;
        end
      end
      S_PEND: begin
        w_imem_ren  = 1'b1;
        w_pending   = 1'b1;
        w_pc_sel    = 1'b1;
        w_pc_target = (ihit && !halt && w_ex_override) ? w_ex_target : r_held_target;
        if (halt) begin
          w_clear      = 1'b1;
          w_next_state = S_HALT;
        end else if (ihit) begin
          w_pc_en      = 1'b1;
          w_flush_ifid = 1'b1;
          w_flush_idex = r_held_ex | w_ex_override;
          w_clear      = 1'b1;
          w_next_state = S_RUN;
        end else if (w_ex_override) begin
          // A held ID jump is younger than the EX redirect, so EX replaces it.
          w_load = 1'b1;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next_state = S_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= RESET_STATE_HALTED ? S_HALT : S_RUN;
      r_held_target <= '0;
      r_held_ex     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_clear) begin
        r_held_target <= '0;
        r_held_ex     <= 1'b0;
      end else if (w_load) begin
        r_held_target <= w_req_target;
        r_held_ex     <= w_req_ex;
      end
    end
  end

  // Every output is forced low for the whole time reset is held.
  assign pc_en            = w_pc_en & ~RST;
  assign pc_sel           = w_pc_sel & ~RST;
  assign pc_target        = RST ? '0 : w_pc_target;
  assign flush_ifid       = w_flush_ifid & ~RST;
  assign flush_idex       = w_flush_idex & ~RST;
  assign imemREN          = w_imem_ren & ~RST;
  assign redirect_pending = w_pending & ~RST;
  assign halted           = w_halted & ~RST;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed bench with a redirect model and per-cycle comparison
module tb_fetch_redirect_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, stall, halt;
  logic        ex_br_req, ex_jr_req, id_j_req;
  logic [31:0] ex_br_target, ex_jr_target, id_j_target;
  logic        pc_en, pc_sel, flush_ifid, flush_idex, imemREN, redirect_pending, halted;
  logic [31:0] pc_target;

  int checks = 0;
  int errors = 0;

  fetch_redirect_ctrl #(.WORD_W(32), .RESET_STATE_HALTED(1'b0)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .halt(halt),
    .ex_br_req(ex_br_req), .ex_br_target(ex_br_target),
    .ex_jr_req(ex_jr_req), .ex_jr_target(ex_jr_target),
    .id_j_req(id_j_req), .id_j_target(id_j_target),
    .pc_en(pc_en), .pc_sel(pc_sel), .pc_target(pc_target),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .imemREN(imemREN),
    .redirect_pending(redirect_pending), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Model state: frozen flag, and an optional held redirect (target, came-from-EX).
  bit          m_frozen;
  bit          m_has_hold;
  logic [31:0] m_hold_tgt;
  bit          m_hold_ex;

  typedef struct packed {
    logic        pc_en;
    logic        pc_sel;
    logic [31:0] tgt;
    logic        fi;
    logic        fx;
    logic        ren;
    logic        pend;
    logic        hlt;
  } obs_t;

  function automatic obs_t model_now();
    obs_t        e;
    bit          any_ex, any_req, accept, ex_steals;
    logic [31:0] win_tgt, ex_tgt;
    e = '0;
    if (RST) return e;
    if (m_frozen) begin
      e.hlt = 1'b1;
      return e;
    end
    any_ex  = ex_br_req || ex_jr_req;
    any_req = any_ex || id_j_req;
    ex_tgt  = ex_br_req ? ex_br_target : ex_jr_target;
    win_tgt = any_ex ? ex_tgt : id_j_target;
    accept  = ihit && !halt;
    e.ren   = 1'b1;
    if (m_has_hold) begin
      ex_steals = any_ex && !m_hold_ex && accept;
      e.pend    = 1'b1;
      e.pc_sel  = 1'b1;
      e.tgt     = ex_steals ? ex_tgt : m_hold_tgt;
      if (accept) begin
        e.pc_en = 1'b1;
        e.fi    = 1'b1;
        e.fx    = m_hold_ex || ex_steals;
      end
    end else if (any_req) begin
      e.pc_sel = 1'b1;
      e.tgt    = win_tgt;
      if (accept) begin
        e.pc_en = 1'b1;
        e.fi    = 1'b1;
        e.fx    = any_ex;
      end
    end else if (!halt) begin
      e.pc_en = ihit && !stall;
    end
    return e;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_frozen   <= 1'b0;
      m_has_hold <= 1'b0;
      m_hold_tgt <= '0;
      m_hold_ex  <= 1'b0;
    end else if (!m_frozen) begin
      if (halt) begin
        m_frozen   <= 1'b1;
        m_has_hold <= 1'b0;
      end else if (m_has_hold) begin
        if (ihit) m_has_hold <= 1'b0;
        else if ((ex_br_req || ex_jr_req) && !m_hold_ex) begin
          m_hold_tgt <= ex_br_req ? ex_br_target : ex_jr_target;
          m_hold_ex  <= 1'b1;
        end
      end else if ((ex_br_req || ex_jr_req || id_j_req) && !ihit) begin
        m_has_hold <= 1'b1;
        m_hold_ex  <= ex_br_req || ex_jr_req;
        m_hold_tgt <= ex_br_req ? ex_br_target : (ex_jr_req ? ex_jr_target : id_j_target);
      end
    end
  end

  always @(negedge CLK) begin
    obs_t act, exp_o;
    act   = '{pc_en, pc_sel, pc_target, flush_ifid, flush_idex, imemREN, redirect_pending, halted};
    exp_o = model_now();
    checks++;
    if (act !== exp_o) begin
      errors++;
      $display("FAIL model_cmp t=%0t got %h expected %h", $time, act, exp_o);
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic step(input logic i_hit, input logic i_stall, input logic i_halt,
                      input logic br, input logic [31:0] brt,
                      input logic jr, input logic [31:0] jrt,
                      input logic j, input logic [31:0] jt);
    @(posedge CLK);
    #1;
    ihit = i_hit; stall = i_stall; halt = i_halt;
    ex_br_req = br; ex_br_target = brt;
    ex_jr_req = jr; ex_jr_target = jrt;
    id_j_req = j; id_j_target = jt;
    #5;
  endtask

  task automatic idle(input logic i_hit);
    step(i_hit, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    ihit = 1'b0; stall = 1'b0; halt = 1'b0;
    ex_br_req = 1'b0; ex_jr_req = 1'b0; id_j_req = 1'b0;
    ex_br_target = '0; ex_jr_target = '0; id_j_target = '0;
    @(posedge CLK); #6;
    lit("reset_pc_en", {31'b0, pc_en}, 32'd0);
    lit("reset_imemREN", {31'b0, imemREN}, 32'd0);
    lit("reset_halted", {31'b0, halted}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      lit("run_pc_en", {31'b0, pc_en}, 32'd1);
      lit("run_pc_sel", {31'b0, pc_sel}, 32'd0);
      lit("run_imemREN", {31'b0, imemREN}, 32'd1);
      lit("run_flush", {30'b0, flush_ifid, flush_idex}, 32'd0);
    end

    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h1000);
    lit("prio_target", pc_target, 32'h40);
    lit("prio_sel_flush", {28'b0, pc_sel, pc_en, flush_ifid, flush_idex}, 32'hF);

    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200);
    lit("idmiss_pc_en", {31'b0, pc_en}, 32'd0);
    idle(1'b0);
    lit("pend_flag", {31'b0, redirect_pending}, 32'd1);
    idle(1'b0);
    lit("pend_pc_en", {31'b0, pc_en}, 32'd0);
    idle(1'b1);
    lit("pend_accept_tgt", pc_target, 32'h200);
    lit("pend_accept_flags", {29'b0, pc_en, flush_ifid, flush_idex}, 32'b110);
    idle(1'b1);
    lit("back_to_run", {30'b0, redirect_pending, pc_sel}, 32'd0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0);
    lit("replace_still_old", pc_target, 32'h200);
    idle(1'b1);
    lit("replace_tgt", pc_target, 32'h300);
    lit("replace_idex", {31'b0, flush_idex}, 32'd1);

    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h500);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 32'h0);
    lit("ex_same_cycle_tgt", pc_target, 32'h600);
    lit("ex_same_cycle_idex", {31'b0, flush_idex}, 32'd1);

    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 32'h0);
    idle(1'b1);
    lit("held_ex_kept", pc_target, 32'h700);

    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    lit("stall_pc_en", {31'b0, pc_en}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
    lit("stall_redirect_en", {31'b0, pc_en}, 32'd1);
    lit("stall_redirect_tgt", pc_target, 32'h80);

    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h900);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    lit("halt_cycle_pc_en", {31'b0, pc_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 32'h0, 1'b1, 32'hB0);
      lit("halted_flags", {29'b0, halted, pc_en, imemREN}, 32'b100);
    end

    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    lit("rst_mid_halt", {24'b0, pc_en, pc_sel, flush_ifid, flush_idex, imemREN,
                         redirect_pending, halted, |pc_target}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle(1'b1);
    lit("after_rst_run", {30'b0, halted, pc_en}, 32'b01);

    @(posedge CLK); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Sequences the program counter unit and instruction fetch port. It arbitrates PC redirect requests from the ID stage (jump) and the EX stage (branch taken, jump-register). Redirects that arrive while the instruction memory is not ready are held until ihit. The block drives the PC enable, next-PC select/target and IF/ID and ID/EX flushes, and freezes fetch on halt. It sits between the hazard unit, the PC unit and the instruction cache.

Parameters:
WORD_W, 32, width of PC and target addresses
RESET_STATE_HALTED, 0, if 1 the block leaves reset in HALT (bring-up use only)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
ihit  in  1  instruction memory returned valid data this cycle
stall  in  1  hazard unit requests IF/ID hold (load-use)
halt  in  1  halt instruction committed in WB
ex_br_req  in  1  EX stage: branch taken
ex_br_target  in  WORD_W  branch target
ex_jr_req  in  1  EX stage: jump-register
ex_jr_target  in  WORD_W  register target
id_j_req  in  1  ID stage: jump/jal
id_j_target  in  WORD_W  jump target
pc_en  out  1  PC register load enable
pc_sel  out  1  0 = PC+4, 1 = load pc_target
pc_target  out  WORD_W  redirect address
flush_ifid  out  1  squash IF/ID latch
flush_idex  out  1  squash ID/EX latch
imemREN  out  1  instruction fetch read enable
redirect_pending  out  1  a held redirect awaits ihit
halted  out  1  block in HALT state

Behaviour:
- States: RUN, PEND, HALT. RST asserted (asynchronous) -> RUN (or HALT per parameter), pending target/source cleared. While RST is high all outputs are 0, and pc_target is 0.
- Request priority (combinational): ex_br_req > ex_jr_req > id_j_req. EX beats ID because the older instruction wins. ex_br_req and ex_jr_req together is illegal; branch wins and no error is flagged.
- RUN, no request: pc_sel=0, pc_en = ihit & ~stall, no flush, imemREN=1.
- RUN, request & ihit: accept in the same cycle with pc_en=1 and pc_sel=1, ignoring stall. pc_target = winning target, flush_ifid=1, flush_idex=1 only if the source is EX. Stay in RUN.
- RUN, request & ~ihit: register target and source (EX/ID), go to PEND next cycle. pc_en=0 and no flush this cycle.
- PEND: redirect_pending=1, pc_sel=1, pc_target = held target, imemREN=1.
  - ihit: pc_en=1, flushes per held source, go to RUN.
  - New EX request while the held source is ID: replace the held target/source.
  - Any other new request: ignore it; that instruction is younger and will be squashed.
  - An EX request in the same cycle as ihit with held source ID: the EX target is used directly.
- Flushes are single-cycle pulses asserted only on the accept cycle.
- halt (any state, highest priority): next state HALT. In the halt cycle itself pc_en=0 and any pending redirect is discarded.
- HALT: pc_en=0, imemREN=0, flushes 0, halted=1, pc_sel=0. Leaves only via RST.
- No arithmetic is performed. Targets pass through unmodified at WORD_W bits; alignment is the producer's responsibility.
- Latency: a redirect takes effect in the PC at the first rising edge where ihit=1, on or after the request cycle. Minimum is 0 extra cycles; unbounded while ihit=0.

Test Plan:
- Reset, ihit=1 each cycle, no requests -> pc_en=1 and pc_sel=0 every cycle, imemREN=1, flushes 0.
- ihit=1, ex_br_req=1 with ex_br_target=0x0000_0040 and id_j_req=1 with id_j_target=0x0000_1000 in the same cycle -> pc_target=0x40, pc_sel=1, flush_ifid=1, flush_idex=1 that cycle.
- id_j_req with target 0x200 and ihit=0 for 3 cycles, then ihit=1 -> redirect_pending=1 for 3 cycles, pc_en=0, then pc_en=1 with pc_target=0x200, flush_ifid=1, flush_idex=0, then RUN.
- While PEND holds ID target 0x200, ex_jr_req with target 0x300 and ihit=0, then ihit -> accepted pc_target=0x300 with flush_idex=1.
- stall=1 with ihit=1 and no request -> pc_en=0. stall=1 with ex_br_req (target 0x80) -> pc_en=1, pc_target=0x80.
- halt=1 while in PEND -> halted=1 next cycle, pc_en=0, imemREN=0 thereafter despite ihit/requests. Pulse RST mid-HALT -> all outputs 0 during reset, RUN after release.
